// File: rtl/multiplier_pkg.sv
// Shared types and constants for the multiplier arbiter slice.
// Holds the state encoding, requester indices and datapath widths.
package multiplier_pkg;
  localparam int OP_W        = 8;
  localparam int PROD_W      = 16;
  localparam int TIMEOUT_DEF = 32;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/mul_watchdog.sv
// Run-cycle counter for a shared multiplier job.
// Flags expiry in the RUN cycle where the count reaches TIMEOUT-1.
module mul_watchdog
  import multiplier_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  assign expire = en && (cnt_q == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multiplier_arbiter.sv
// Round-robin front end sharing one 8x8 multiplier between two requesters.
// Latches operands at grant, returns per-requester results, aborts hung jobs.
module multiplier_arbiter
  import multiplier_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              Req0_Sig,
  input  logic              Req1_Sig,
  input  logic [OP_W-1:0]   A0,
  input  logic [OP_W-1:0]   B0,
  input  logic [OP_W-1:0]   A1,
  input  logic [OP_W-1:0]   B1,
  output logic              Done0_Sig,
  output logic              Done1_Sig,
  output logic [PROD_W-1:0] Product0,
  output logic [PROD_W-1:0] Product1,
  output logic              Mul_Start_Sig,
  output logic [OP_W-1:0]   Mul_A,
  output logic [OP_W-1:0]   Mul_B,
  input  logic              Mul_Done_Sig,
  input  logic [PROD_W-1:0] Mul_Product,
  output logic              Owner,
  output logic              Busy,
  output logic              Timeout_Sig
);

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic              owner_q, owner_d;
  logic              start_q, start_d;
  logic [OP_W-1:0]   mul_a_q, mul_a_d;
  logic [OP_W-1:0]   mul_b_q, mul_b_d;
  logic [PROD_W-1:0] prod0_q, prod0_d;
  logic [PROD_W-1:0] prod1_q, prod1_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;
  logic              tmo_q, tmo_d;
  logic              grant;
  logic              wd_clr;
  logic              wd_expire;
  logic              finish;
  logic [PROD_W-1:0] result;

  mul_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wd (
    .clk    (CLK),
    .rst_n  (RSTn),
    .clr    (wd_clr),
    .en     (state_q == S_RUN),
    .expire (wd_expire)
  );

  // On a tie the requester not served last wins.
  always_comb begin
    grant = REQ0;
    unique case (1'b1)
      Req0_Sig && Req1_Sig:  grant = ~last_q;
      Req1_Sig && !Req0_Sig: grant = REQ1;
      default:               grant = REQ0;
    endcase
  end

  // A same-cycle Mul_Done beats the watchdog.
  assign finish = Mul_Done_Sig || wd_expire;
  assign result = Mul_Done_Sig ? Mul_Product : '0;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    start_d = start_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    prod0_d = prod0_q;
    prod1_d = prod1_q;
    done0_d = 1'b0;
    done1_d = 1'b0;
    tmo_d   = 1'b0;
    wd_clr  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (Req0_Sig || Req1_Sig) begin
          owner_d = grant;
          mul_a_d = grant ? A1 : A0;
          mul_b_d = grant ? B1 : B0;
          start_d = 1'b1;
          wd_clr  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (finish) begin
          start_d = 1'b0;
          last_d  = owner_q;
          tmo_d   = !Mul_Done_Sig;
          state_d = S_DONE;
          if (owner_q == REQ1) begin
            prod1_d = result;
            done1_d = 1'b1;
          end else begin
            prod0_d = result;
            done0_d = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        start_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= S_IDLE;
      last_q  <= REQ1;
      owner_q <= REQ0;
      start_q <= 1'b0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      prod0_q <= '0;
      prod1_q <= '0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      start_q <= start_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      prod0_q <= prod0_d;
      prod1_q <= prod1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      tmo_q   <= tmo_d;
    end
  end

  assign Done0_Sig     = done0_q;
  assign Done1_Sig     = done1_q;
  assign Product0      = prod0_q;
  assign Product1      = prod1_q;
  assign Mul_Start_Sig = start_q;
  assign Mul_A         = mul_a_q;
  assign Mul_B         = mul_b_q;
  assign Owner         = owner_q;
  assign Busy          = (state_q != S_IDLE);
  assign Timeout_Sig   = tmo_q;

endmodule

// File: tb/tb_multiplier_arbiter.sv
// Bench for multiplier_arbiter: job-level model, multiplier stub,
// per-cycle output comparison and directed scenario checks.
module tb_multiplier_arbiter;
  localparam int TMO = 32;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        Req0_Sig = 1'b0;
  logic        Req1_Sig = 1'b0;
  logic [7:0]  A0 = '0;
  logic [7:0]  B0 = '0;
  logic [7:0]  A1 = '0;
  logic [7:0]  B1 = '0;
  logic        Done0_Sig;
  logic        Done1_Sig;
  logic [15:0] Product0;
  logic [15:0] Product1;
  logic        Mul_Start_Sig;
  logic [7:0]  Mul_A;
  logic [7:0]  Mul_B;
  logic        Mul_Done_Sig = 1'b0;
  logic [15:0] Mul_Product = '0;
  logic        Owner;
  logic        Busy;
  logic        Timeout_Sig;

  int checks = 0;
  int errors = 0;

  logic [15:0] q0[$];
  logic [15:0] q1[$];
  int          mul_lat = 10;
  int          mcnt = 0;
  logic        force_done = 1'b0;

  multiplier_arbiter #(.TIMEOUT(TMO)) dut (
    .CLK           (CLK),
    .RSTn          (RSTn),
    .Req0_Sig      (Req0_Sig),
    .Req1_Sig      (Req1_Sig),
    .A0            (A0),
    .B0            (B0),
    .A1            (A1),
    .B1            (B1),
    .Done0_Sig     (Done0_Sig),
    .Done1_Sig     (Done1_Sig),
    .Product0      (Product0),
    .Product1      (Product1),
    .Mul_Start_Sig (Mul_Start_Sig),
    .Mul_A         (Mul_A),
    .Mul_B         (Mul_B),
    .Mul_Done_Sig  (Mul_Done_Sig),
    .Mul_Product   (Mul_Product),
    .Owner         (Owner),
    .Busy          (Busy),
    .Timeout_Sig   (Timeout_Sig)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Requesters and multiplier stub, driven just after each rising edge.
  always @(posedge CLK) begin
    #1;
    if (Done0_Sig && q0.size() > 0) void'(q0.pop_front());
    if (Done1_Sig && q1.size() > 0) void'(q1.pop_front());
    Req0_Sig = (q0.size() > 0);
    Req1_Sig = (q1.size() > 0);
    if (q0.size() > 0) {A0, B0} = q0[0];
    if (q1.size() > 0) {A1, B1} = q1[0];
    Mul_Done_Sig = 1'b0;
    if (force_done) begin
      Mul_Done_Sig = 1'b1;
      Mul_Product  = 16'hBEEF;
    end else if (Mul_Start_Sig) begin
      mcnt++;
      if (mcnt == mul_lat) begin
        Mul_Done_Sig = 1'b1;
        Mul_Product  = 16'(Mul_A) * 16'(Mul_B);
      end
    end else begin
      mcnt = 0;
    end
  end

  // Job-level model: m_age is cycles into the current job (-1 = none),
  // m_post marks the single completion-report cycle.
  int          m_age;
  logic        m_post, m_last, m_pick;
  logic        e_start, e_owner, e_busy, e_d0, e_d1, e_to;
  logic [7:0]  e_a, e_b;
  logic [15:0] e_p0, e_p1;

  assign m_pick = (Req0_Sig && Req1_Sig) ? !m_last : Req1_Sig;

  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      m_age <= -1; m_post <= 0; m_last <= 1;
      e_start <= 0; e_owner <= 0; e_busy <= 0;
      e_d0 <= 0; e_d1 <= 0; e_to <= 0;
      e_a <= 0; e_b <= 0; e_p0 <= 0; e_p1 <= 0;
    end else begin
      e_d0 <= 0; e_d1 <= 0; e_to <= 0;
      if (m_post) begin
        m_post <= 0;
        e_busy <= 0;
      end else if (m_age >= 0) begin
        if (Mul_Done_Sig || m_age == TMO - 1) begin
          e_start <= 0;
          m_age   <= -1;
          m_post  <= 1;
          m_last  <= e_owner;
          e_to    <= !Mul_Done_Sig;
          if (e_owner) begin
            e_d1 <= 1;
            e_p1 <= Mul_Done_Sig ? Mul_Product : 16'h0;
          end else begin
            e_d0 <= 1;
            e_p0 <= Mul_Done_Sig ? Mul_Product : 16'h0;
          end
        end else begin
          m_age <= m_age + 1;
        end
      end else if (Req0_Sig || Req1_Sig) begin
        e_owner <= m_pick;
        e_a     <= m_pick ? A1 : A0;
        e_b     <= m_pick ? B1 : B0;
        e_start <= 1;
        e_busy  <= 1;
        m_age   <= 0;
      end
    end
  end

  always @(negedge CLK) begin
    if (RSTn) begin
      chk("done0", Done0_Sig, e_d0);
      chk("done1", Done1_Sig, e_d1);
      chk("prod0", Product0, e_p0);
      chk("prod1", Product1, e_p1);
      chk("start", Mul_Start_Sig, e_start);
      chk("mul_a", Mul_A, e_a);
      chk("mul_b", Mul_B, e_b);
      chk("owner", Owner, e_owner);
      chk("busy", Busy, e_busy);
      chk("timeout", Timeout_Sig, e_to);
    end
  end

  task automatic wait_any(input string nm, output int who);
    who = -1;
    for (int i = 0; i < 300 && who < 0; i++) begin
      @(negedge CLK);
      if (Done0_Sig) who = 0;
      else if (Done1_Sig) who = 1;
    end
    if (who < 0) begin
      checks++;
      errors++;
      $display("FAIL %s: no done pulse within 300 cycles", nm);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit: run did not finish");
    $fatal(1);
  end

  initial begin
    int who;
    int cnt;
    int ghost;
    int exp_own[4];
    exp_own = '{0, 1, 0, 1};

    repeat (3) @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);
    chk("rst_busy", Busy, 0);
    chk("rst_start", Mul_Start_Sig, 0);
    chk("rst_prod0", Product0, 0);

    // Single request, 12 x 10
    q0.push_back({8'd12, 8'd10});
    @(negedge CLK);
    chk("start_t0", Mul_Start_Sig, 0);
    @(negedge CLK);
    chk("start_t1", Mul_Start_Sig, 1);
    chk("lat_a", Mul_A, 12);
    wait_any("single", who);
    chk("single_who", who, 0);
    chk("single_p0", Product0, 120);
    chk("single_p1", Product1, 0);
    chk("single_to", Timeout_Sig, 0);

    // Reset in the middle of a job
    repeat (3) @(negedge CLK);
    q0.push_back({8'd1, 8'd1});
    repeat (5) @(negedge CLK);
    chk("mid_busy", Busy, 1);
    #2 RSTn = 1'b0;
    #1;
    q0.delete();
    chk("rst2_start", Mul_Start_Sig, 0);
    chk("rst2_prod0", Product0, 0);
    chk("rst2_busy", Busy, 0);
    chk("rst2_mula", Mul_A, 0);
    @(negedge CLK);
    #2 RSTn = 1'b1;
    @(negedge CLK);

    // Tie after reset: requester 0 first, 2-cycle start gap
    q0.push_back({8'd3, 8'd4});
    q1.push_back({8'd5, 8'd6});
    wait_any("tie0", who);
    chk("tie_first", who, 0);
    chk("tie_p0", Product0, 12);
    cnt = 0;
    while (!Mul_Start_Sig && cnt < 50) begin
      cnt++;
      @(negedge CLK);
    end
    chk("tie_gap", cnt, 2);
    wait_any("tie1", who);
    chk("tie_second", who, 1);
    chk("tie_p1", Product1, 30);

    // Fairness over four jobs
    repeat (3) @(negedge CLK);
    q0.push_back({8'd2, 8'd3});
    q0.push_back({8'd6, 8'd7});
    q1.push_back({8'd4, 8'd5});
    q1.push_back({8'd8, 8'd9});
    for (int k = 0; k < 4; k++) begin
      wait_any("fair", who);
      chk($sformatf("fair_own%0d", k), who, exp_own[k]);
    end
    chk("fair_p0", Product0, 42);
    chk("fair_p1", Product1, 72);

    // Hung multiplier: watchdog abort after 32 RUN cycles
    repeat (3) @(negedge CLK);
    mul_lat = 0;
    q0.push_back({8'd7, 8'd9});
    cnt = 0;
    who = -1;
    for (int i = 0; i < 300 && who < 0; i++) begin
      @(negedge CLK);
      if (Done0_Sig) who = 0;
      else if (Mul_Start_Sig) cnt++;
    end
    chk("tmo_seen", who, 0);
    chk("tmo_cycles", cnt, 32);
    chk("tmo_pulse", Timeout_Sig, 1);
    chk("tmo_p0", Product0, 16'h0000);

    // Stray Mul_Done while idle
    @(negedge CLK);
    force_done = 1'b1;
    @(negedge CLK);
    force_done = 1'b0;
    ghost = 0;
    repeat (4) begin
      @(negedge CLK);
      if (Done0_Sig || Done1_Sig || Busy) ghost++;
    end
    chk("stray_ghost", ghost, 0);
    chk("stray_p0", Product0, 16'h0000);

    // Mul_Done in the expiry cycle wins
    mul_lat = 32;
    q1.push_back({8'd200, 8'd250});
    wait_any("edge", who);
    chk("edge_who", who, 1);
    chk("edge_to", Timeout_Sig, 0);
    chk("edge_p1", Product1, 50000);
    chk("edge_p0", Product0, 0);

    repeat (4) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
